tick_debouncer: RTL and testbench

- Downstream consumer of the divider's Timeout strobe; uses it as a sample enable (Tick) to debounce one raw push-button/switch input.
- Produces a clean level plus one-Clock press and release pulses for the board-level control logic (start/step/reset-weights buttons of the network demo).
- Contains an input synchronizer, a 4-state FSM and a stable-sample counter.

---
 rtl/tick_debouncer_pkg.sv | 19 +
 rtl/tick_debouncer_sync2_ff.sv | 29 ++
 rtl/tick_debouncer.sv | 143 ++++++++++++++
 tb/tb_tick_debouncer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tick_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// tick_debouncer_pkg : state encodings and default sizing for tick_debouncer
// Revision 1.0
// ============================================================================
package tick_debouncer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE_LOW  = 2'b00;
   localparam state_t ARM_HIGH  = 2'b01;
   localparam state_t HELD_HIGH = 2'b10;
   localparam state_t ARM_LOW   = 2'b11;

   localparam int DEFAULT_STABLE_TICKS = 4;
   localparam int DEFAULT_COUNT_BITS   = 8;

endpackage
`default_nettype wire

// File: rtl/tick_debouncer_sync2_ff.sv
`default_nettype none
// ============================================================================
// sync2_ff : two-flop synchronizer for an asynchronous level, resets to 0
// Revision 1.0
// ============================================================================
module sync2_ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s0 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s0 <= r_s1;
      end
   end

   assign o_q = r_s0;

endmodule
`default_nettype wire

// File: rtl/tick_debouncer.sv
`default_nettype none
// ============================================================================
// tick_debouncer : Tick-sampled button debouncer with press/release pulses
// Revision 1.0
// ============================================================================
module tick_debouncer
   import tick_debouncer_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter int COUNT_BITS   = DEFAULT_COUNT_BITS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_raw_in,
   output logic o_debounced,
   output logic o_press_pulse,
   output logic o_release_pulse
);

   localparam logic [COUNT_BITS-1:0] c_STABLE = COUNT_BITS'(STABLE_TICKS);
   localparam logic [COUNT_BITS-1:0] c_ONE    = COUNT_BITS'(1);
   localparam logic [COUNT_BITS-1:0] c_ZERO   = '0;

   logic                  w_s0;
   state_t                r_state;
   state_t                w_next_state;
   logic [COUNT_BITS-1:0] r_count;
   logic [COUNT_BITS-1:0] w_next_count;
   logic [COUNT_BITS-1:0] w_count_inc;
   logic                  w_accept_high;
   logic                  w_accept_low;
   logic                  w_debounced_nxt;
   logic                  w_press_nxt;
   logic                  w_release_nxt;
   logic                  r_debounced;
   logic                  r_press;
   logic                  r_release;

   sync2_ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (i_raw_in),
      .o_q   (w_s0)
   );

   assign w_count_inc = r_count + c_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE_LOW;
         r_count     <= c_ZERO;
         r_debounced <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_count     <= w_next_count;
         r_debounced <= w_debounced_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_count  = r_count;
      w_accept_high = 1'b0;
      w_accept_low  = 1'b0;
      case (r_state)
         IDLE_LOW: begin
            if (i_tick && w_s0) begin
               // A single-sample build accepts on the first contrary sample
               if (STABLE_TICKS == 1) begin
                  w_next_state  = HELD_HIGH;
                  w_next_count  = c_ZERO;
                  w_accept_high = 1'b1;
               end else begin
                  w_next_state = ARM_HIGH;
                  w_next_count = c_ONE;
               end
            end
         end
         ARM_HIGH: begin
            if (i_tick) begin
               if (!w_s0) begin
                  w_next_state = IDLE_LOW;
                  w_next_count = c_ZERO;
               end else if (w_count_inc == c_STABLE) begin
                  w_next_state  = HELD_HIGH;
                  w_next_count  = c_ZERO;
                  w_accept_high = 1'b1;
               end else begin
                  w_next_count = w_count_inc;
               end
            end
         end
         HELD_HIGH: begin
            if (i_tick && !w_s0) begin
               if (STABLE_TICKS == 1) begin
                  w_next_state = IDLE_LOW;
                  w_next_count = c_ZERO;
                  w_accept_low = 1'b1;
               end else begin
                  w_next_state = ARM_LOW;
                  w_next_count = c_ONE;
               end
            end
         end
         ARM_LOW: begin
            if (i_tick) begin
               if (w_s0) begin
                  w_next_state = HELD_HIGH;
                  w_next_count = c_ZERO;
               end else if (w_count_inc == c_STABLE) begin
                  w_next_state = IDLE_LOW;
                  w_next_count = c_ZERO;
                  w_accept_low = 1'b1;
               end else begin
                  w_next_count = w_count_inc;
               end
            end
         end
         default: begin
            w_next_state = IDLE_LOW;
            w_next_count = c_ZERO;
         end
      endcase
   end

   // Outputs are registered from the next state so they land with the transition
   always_comb begin
      w_debounced_nxt = (w_next_state == HELD_HIGH) || (w_next_state == ARM_LOW);
      w_press_nxt     = w_accept_high;
      w_release_nxt   = w_accept_low;
   end

   assign o_debounced     = r_debounced;
   assign o_press_pulse   = r_press;
   assign o_release_pulse = r_release;

endmodule
`default_nettype wire

// File: tb/tb_tick_debouncer.sv
`default_nettype none
// ============================================================================
// tb_tick_debouncer : vector-table and directed checks of tick_debouncer
// Revision 1.0
// ============================================================================
module tb_tick_debouncer;

   typedef struct {
      logic rst_n;
      logic tick;
      logic raw;
      int   n;
      logic deb;
      logic press;
      logic rel;
   } vec_t;

   logic clk = 1'b0;
   logic a_rst_n, a_tick, a_raw, a_deb, a_press, a_rel;
   logic b_rst_n, b_tick, b_raw, b_deb, b_press, b_rel;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   tick_debouncer #(.STABLE_TICKS(4), .COUNT_BITS(8)) u_dut_a (
      .clk             (clk),
      .rst_n           (a_rst_n),
      .i_tick          (a_tick),
      .i_raw_in        (a_raw),
      .o_debounced     (a_deb),
      .o_press_pulse   (a_press),
      .o_release_pulse (a_rel)
   );

   tick_debouncer #(.STABLE_TICKS(1), .COUNT_BITS(8)) u_dut_b (
      .clk             (clk),
      .rst_n           (b_rst_n),
      .i_tick          (b_tick),
      .i_raw_in        (b_raw),
      .o_debounced     (b_deb),
      .o_press_pulse   (b_press),
      .o_release_pulse (b_rel)
   );

   function automatic vec_t mk(logic r, logic t, logic w, int n, logic d, logic p, logic l);
      vec_t v;
      v.rst_n = r; v.tick = t; v.raw = w; v.n = n;
      v.deb = d; v.press = p; v.rel = l;
      return v;
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, check 1 time unit after the rising edge
   task automatic step(input bit sel, input logic r, input logic t, input logic w,
                       input logic ed, input logic ep, input logic er, input string nm);
      @(negedge clk);
      if (!sel) begin a_rst_n = r; a_tick = t; a_raw = w; end
      else      begin b_rst_n = r; b_tick = t; b_raw = w; end
      @(posedge clk);
      #1;
      if (!sel) begin
         chk({nm, ".deb"}, a_deb, ed);
         chk({nm, ".press"}, a_press, ep);
         chk({nm, ".rel"}, a_rel, er);
      end else begin
         chk({nm, ".deb"}, b_deb, ed);
         chk({nm, ".press"}, b_press, ep);
         chk({nm, ".rel"}, b_rel, er);
      end
   endtask

   initial begin
      a_rst_n = 1'b0; a_tick = 1'b0; a_raw = 1'b1;
      b_rst_n = 1'b0; b_tick = 1'b0; b_raw = 1'b0;

      // Reset held with RawIn=1 and Tick toggling
      vecs.push_back(mk(0,1,1,1,0,0,0)); vecs.push_back(mk(0,0,1,1,0,0,0));
      vecs.push_back(mk(0,1,1,2,0,0,0));
      // Release, fill synchronizer, Tick every 4th clock
      vecs.push_back(mk(1,0,1,2,0,0,0));
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(mk(1,0,1,3,0,0,0)); vecs.push_back(mk(1,1,1,1,0,0,0));
      end
      vecs.push_back(mk(1,0,1,3,0,0,0)); vecs.push_back(mk(1,1,1,1,1,1,0));
      vecs.push_back(mk(1,0,1,5,1,0,0));
      // Release path with consecutive ticks
      vecs.push_back(mk(1,0,0,2,1,0,0)); vecs.push_back(mk(1,1,0,3,1,0,0));
      vecs.push_back(mk(1,1,0,1,0,0,1)); vecs.push_back(mk(1,0,0,2,0,0,0));
      // Tick held high 4 clocks with RawIn stable high
      vecs.push_back(mk(1,0,1,2,0,0,0)); vecs.push_back(mk(1,1,1,3,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,1,0)); vecs.push_back(mk(1,0,1,1,1,0,0));
      // Single low sample, then back high: no change
      vecs.push_back(mk(1,0,0,2,1,0,0)); vecs.push_back(mk(1,1,0,1,1,0,0));
      vecs.push_back(mk(1,0,1,2,1,0,0)); vecs.push_back(mk(1,1,1,4,1,0,0));
      // RawIn moves with Tick low for 100 clocks
      vecs.push_back(mk(1,0,0,30,1,0,0)); vecs.push_back(mk(1,0,1,30,1,0,0));
      vecs.push_back(mk(1,0,0,40,1,0,0));
      vecs.push_back(mk(1,1,0,3,1,0,0)); vecs.push_back(mk(1,1,0,1,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0));
      // Bounce 1,1,0,1,1,1,1 across samples
      vecs.push_back(mk(1,0,1,2,0,0,0)); vecs.push_back(mk(1,1,1,1,0,0,0));
      vecs.push_back(mk(1,0,1,2,0,0,0)); vecs.push_back(mk(1,1,1,1,0,0,0));
      vecs.push_back(mk(1,0,0,2,0,0,0)); vecs.push_back(mk(1,1,0,1,0,0,0));
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(mk(1,0,1,2,0,0,0)); vecs.push_back(mk(1,1,1,1,0,0,0));
      end
      vecs.push_back(mk(1,0,1,2,0,0,0)); vecs.push_back(mk(1,1,1,1,1,1,0));
      vecs.push_back(mk(1,0,1,3,1,0,0));

      for (int i = 0; i < vecs.size(); i++)
         for (int k = 0; k < vecs[i].n; k++)
            step(1'b0, vecs[i].rst_n, vecs[i].tick, vecs[i].raw,
                 vecs[i].deb, vecs[i].press, vecs[i].rel, $sformatf("vec%0d_%0d", i, k));

      // Asynchronous reset clears Debounced without a clock edge
      #2 a_rst_n = 1'b0;
      #1 chk("async_rst.deb", a_deb, 1'b0);
      // Mid-ARM reset after 3 of 4 samples
      step(1'b0, 1, 0, 1, 0, 0, 0, "arm_fill0");
      step(1'b0, 1, 0, 1, 0, 0, 0, "arm_fill1");
      for (int k = 0; k < 3; k++) step(1'b0, 1, 1, 1, 0, 0, 0, $sformatf("arm_s%0d", k));
      step(1'b0, 0, 0, 1, 0, 0, 0, "arm_rst0");
      step(1'b0, 0, 0, 1, 0, 0, 0, "arm_rst1");
      step(1'b0, 1, 0, 1, 0, 0, 0, "re_fill0");
      step(1'b0, 1, 0, 1, 0, 0, 0, "re_fill1");
      for (int k = 0; k < 3; k++) step(1'b0, 1, 1, 1, 0, 0, 0, $sformatf("re_s%0d", k));
      step(1'b0, 1, 1, 1, 1, 1, 0, "re_s3");
      // Reset during the press pulse kills it at once
      #1 a_rst_n = 1'b0;
      #1 chk("pulse_rst.press", a_press, 1'b0);
      chk("pulse_rst.deb", a_deb, 1'b0);
      step(1'b0, 1, 0, 1, 0, 0, 0, "post_rst0");
      step(1'b0, 1, 0, 1, 0, 0, 0, "post_rst1");

      // Single-sample build: 1,0,1 gives press, release, press
      step(1'b1, 0, 1, 0, 0, 0, 0, "b_rst");
      step(1'b1, 1, 0, 1, 0, 0, 0, "b_f0");
      step(1'b1, 1, 0, 1, 0, 0, 0, "b_f1");
      step(1'b1, 1, 1, 1, 1, 1, 0, "b_press1");
      step(1'b1, 1, 0, 0, 1, 0, 0, "b_clr1");
      step(1'b1, 1, 0, 0, 1, 0, 0, "b_f2");
      step(1'b1, 1, 1, 0, 0, 0, 1, "b_rel");
      step(1'b1, 1, 0, 1, 0, 0, 0, "b_clr2");
      step(1'b1, 1, 0, 1, 0, 0, 0, "b_f3");
      step(1'b1, 1, 1, 1, 1, 1, 0, "b_press2");
      step(1'b1, 1, 1, 1, 1, 0, 0, "b_hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
